pipe_ctrl: RTL and testbench

Parametrised pipeline hazard controller: the next-generation replacement for the fixed-width stall controller. It merges per-stage stall requests into per-stage stall and bubble controls, turns flush requests into per-stage flush controls, and sequences multi-cycle operations (divide, multiply) with an internal down-counter. It holds back a flush raised behind an older stalling stage. It also keeps a saturating stall-cycle counter for debug. It sits beside the datapath and drives the enable/clear inputs of every pipeline register (stage 0 = pc, 1 = id, 2 = ex, 3 = mem, 4 = wb for the default configuration).

---
 rtl/pipe_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- pipeline hazard controller
//
// Merges per-stage stall requests into per-stage stall/bubble controls,
// converts flush requests into per-stage flush controls (holding back a
// flush raised behind an older stalling stage), sequences a multi-cycle
// operation hosted in stage MC_STAGE, and counts stalled cycles for debug.
// Stage 0 is the youngest stage (pc); stage STAGES-1 is the oldest.
//
// Parameters:
//   STAGES    number of pipeline stages
//   MC_STAGE  stage hosting the multi-cycle unit (must be < STAGES)
//   CNT_W     width of the multi-cycle length field
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   stallreq      per-stage stall request (level)
//   flushreq      bit i kills stages 0..i-1 (pulse)
//   mc_start      start a multi-cycle op (pulse)
//   mc_cycles     op length in cycles, sampled with mc_start
//   stall         per-stage hold
//   bubble        bit i: insert a NOP between stage i and i+1
//   flush         per-stage clear
//   mc_busy       multi-cycle op in progress (combinational)
//   mc_done       one-cycle pulse the cycle after an op completes normally
//   stall_cycles  saturating count of cycles with stall[0]=1
//   dbg_state     current multi-cycle FSM state (1 = BUSY)
//
// Multi-cycle handshake: mc_start is a single-cycle request taken only
// while the unit is idle (ignored while busy). An op of N>=1 cycles holds
// mc_busy for exactly N cycles starting with the mc_start cycle, and
// mc_done pulses for one cycle right after the last busy cycle. An op
// aborted by a flush of MC_STAGE never produces mc_done. N=0 produces no
// busy cycle and mc_done on the following cycle.
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int STAGES   = 5,
    parameter int MC_STAGE = 2,
    parameter int CNT_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq,
    input  logic [STAGES-1:0] flushreq,
    input  logic              mc_start,
    input  logic [CNT_W-1:0]  mc_cycles,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-2:0] bubble,
    output logic [STAGES-1:0] flush,
    output logic              mc_busy,
    output logic              mc_done,
    output logic [31:0]       stall_cycles,
    output logic              dbg_state
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mc_state_e;

    mc_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STAGES-1:0] pend_q, pend_d;
    logic              mc_done_q, mc_done_d;
    logic [31:0]       stall_cycles_q, stall_cycles_d;

    logic              start_go;
    logic              busy_raw;
    logic              abort;
    logic [STAGES-1:0] req;
    logic [STAGES-1:0] stall_raw;
    logic [STAGES-1:0] flush_raw;
    logic [STAGES-2:0] bubble_raw;
    logic              acc;
    logic              blocked;
    logic              src;

    // Hazard merge: stall, flush and pending-flush bookkeeping.
    always_comb begin
        start_go  = (state_q == ST_IDLE) && mc_start && (mc_cycles != '0);
        busy_raw  = (state_q == ST_BUSY) || start_go;

        req = stallreq;
        if (busy_raw) begin
            req[MC_STAGE] = 1'b1;
        end

        // Walk from the oldest stage down: once any older stage requests a
        // stall, every younger stage is held as well.
        acc       = 1'b0;
        stall_raw = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc          = acc | req[i];
            stall_raw[i] = acc;
        end

        // Same oldest-first walk for flushes. 'blocked' is set once a stage
        // older than the current source requests a stall; a blocked source
        // is parked in pend until the older stage lets go.
        blocked   = 1'b0;
        src       = 1'b0;
        flush_raw = '0;
        pend_d    = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            src = flushreq[k] | pend_q[k];
            if (blocked) begin
                pend_d[k] = src;
            end else if (src) begin
                for (int j = 0; j < STAGES; j++) begin
                    if (j < k) begin
                        flush_raw[j] = 1'b1;
                    end
                end
            end
            blocked = blocked | req[k];
        end

        // Flushed stages never stall or bubble: the flush wins.
        for (int i = 0; i < STAGES - 1; i++) begin
            bubble_raw[i] = stall_raw[i] & ~stall_raw[i+1] & ~flush_raw[i];
        end

        abort = busy_raw && flush_raw[MC_STAGE];
    end

    // Reset forces every control output low in the same cycle.
    always_comb begin
        stall        = rst ? '0 : (stall_raw & ~flush_raw);
        bubble       = rst ? '0 : bubble_raw;
        flush        = rst ? '0 : flush_raw;
        mc_busy      = busy_raw & ~rst;
        mc_done      = mc_done_q & ~rst;
        stall_cycles = stall_cycles_q;
        dbg_state    = (state_q == ST_BUSY);
    end

    // Multi-cycle sequencer. The mc_start cycle is already the first busy
    // cycle, so BUSY is entered with N-2 remaining and leaves at cnt=0;
    // an op of length 1 never enters BUSY at all.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mc_done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (mc_start) begin
                    if (mc_cycles == '0) begin
                        mc_done_d = 1'b1;
                    end else if (!abort) begin
                        if (mc_cycles == CNT_W'(1)) begin
                            mc_done_d = 1'b1;
                        end else begin
                            state_d = ST_BUSY;
                            cnt_d   = mc_cycles - CNT_W'(2);
                        end
                    end
                end
            end
            ST_BUSY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d   = ST_IDLE;
                    mc_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        stall_cycles_d = stall_cycles_q;
        if (stall[0] && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            pend_q         <= '0;
            mc_done_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pend_q         <= pend_d;
            mc_done_q      <= mc_done_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl -- directed and random checks of pipe_ctrl against a
// behavioural model (oldest requesting stage, remaining op length, pending
// flush bits) kept in this file.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int STAGES = 5;
    localparam int MC     = 2;
    localparam int CW     = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [STAGES-1:0] stallreq;
    logic [STAGES-1:0] flushreq;
    logic              mc_start;
    logic [CW-1:0]     mc_cycles;
    logic [STAGES-1:0] stall;
    logic [STAGES-2:0] bubble;
    logic [STAGES-1:0] flush;
    logic              mc_busy;
    logic              mc_done;
    logic [31:0]       stall_cycles;
    logic              dbg_state;

    pipe_ctrl #(.STAGES(STAGES), .MC_STAGE(MC), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq     (stallreq),
        .flushreq     (flushreq),
        .mc_start     (mc_start),
        .mc_cycles    (mc_cycles),
        .stall        (stall),
        .bubble       (bubble),
        .flush        (flush),
        .mc_busy      (mc_busy),
        .mc_done      (mc_done),
        .stall_cycles (stall_cycles),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: remaining busy cycles of the running op, done pulse due
    // this cycle, parked flush sources, stall cycle count.
    int                m_left = 0;
    logic              m_done = 1'b0;
    logic [STAGES-1:0] m_pend = '0;
    logic [31:0]       m_sc   = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, compare every
    // output against the model, then advance the model past the next
    // rising edge.
    task automatic step(input logic r, input logic [STAGES-1:0] sr, input logic [STAGES-1:0] fr,
                        input logic st, input logic [CW-1:0] n);
        logic [STAGES-1:0] e_stall, e_flush, e_pend;
        logic [STAGES-2:0] e_bub;
        logic              e_busy, e_done, nxt_done;
        int                top, cur_left, sfull, fmask;
        logic [STAGES-1:0] req;
        @(negedge clk);
        rst = r; stallreq = sr; flushreq = fr; mc_start = st; mc_cycles = n;
        #1;
        e_stall = '0; e_flush = '0; e_bub = '0; e_busy = 1'b0; e_done = 1'b0;
        e_pend = '0; nxt_done = 1'b0; cur_left = 0; fmask = 0; top = -1;
        if (!r) begin
            cur_left = m_left;
            if (st && m_left == 0) cur_left = int'(n);
            e_busy = (cur_left > 0);
            req = sr;
            if (e_busy) req[MC] = 1'b1;
            for (int i = 0; i < STAGES; i++) if (req[i]) top = i;
            sfull = (top >= 0) ? ((1 << (top + 1)) - 1) : 0;
            for (int k = 0; k < STAGES; k++) begin
                if (fr[k] || m_pend[k]) begin
                    if (top > k) e_pend[k] = 1'b1;
                    else fmask = fmask | ((1 << k) - 1);
                end
            end
            e_flush = fmask[STAGES-1:0];
            e_stall = sfull[STAGES-1:0] & ~e_flush;
            if (top >= 0 && top < STAGES - 1 && !e_flush[top]) e_bub[top] = 1'b1;
            e_done = m_done;
        end
        check("stall", 32'(stall), 32'(e_stall));
        check("bubble", 32'(bubble), 32'(e_bub));
        check("flush", 32'(flush), 32'(e_flush));
        check("mc_busy", 32'(mc_busy), 32'(e_busy));
        check("mc_done", 32'(mc_done), 32'(e_done));
        check("stall_cycles", stall_cycles, m_sc);
        if (r) begin
            m_left = 0; m_pend = '0; m_sc = '0; m_done = 1'b0;
        end else begin
            if (st && m_left == 0 && n == '0) nxt_done = 1'b1;
            if (cur_left > 0) begin
                if (e_flush[MC]) begin
                    cur_left = 0;
                end else begin
                    cur_left = cur_left - 1;
                    if (cur_left == 0) nxt_done = 1'b1;
                end
            end
            m_left = cur_left;
            m_done = nxt_done;
            m_pend = e_pend;
            if (e_stall[0] && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
        end
    endtask

    initial begin
        rst = 1'b1; stallreq = '0; flushreq = '0; mc_start = 1'b0; mc_cycles = '0;

        // Reset, then a mem stall.
        step(1'b1, 5'b0, 5'b0, 1'b0, 6'd0);
        step(1'b1, 5'b0, 5'b0, 1'b0, 6'd0);
        check("rst_stall_cycles", stall_cycles, 32'd0);
        step(1'b0, 5'b01000, 5'b0, 1'b0, 6'd0);
        check("mem_stall", 32'(stall), 32'h0F);
        check("mem_bubble", 32'(bubble), 32'h8);
        check("mem_flush", 32'(flush), 32'h0);
        step(1'b0, 5'b01000, 5'b0, 1'b0, 6'd0);
        step(1'b1, 5'b01000, 5'b0, 1'b0, 6'd0);
        check("rst_out_stall", 32'(stall), 32'h0);
        step(1'b0, 5'b0, 5'b0, 1'b0, 6'd0);
        check("rst_cnt_clear", stall_cycles, 32'd0);

        // Four-cycle op, then a zero-length op.
        step(1'b0, 5'b0, 5'b0, 1'b1, 6'd4);
        check("mc4_stall", 32'(stall), 32'h07);
        for (int i = 0; i < 3; i++) step(1'b0, 5'b0, 5'b0, 1'b0, 6'd0);
        check("mc4_busy_last", 32'(mc_busy), 32'd1);
        step(1'b0, 5'b0, 5'b0, 1'b0, 6'd0);
        check("mc4_done", 32'(mc_done), 32'd1);
        check("mc4_idle", 32'(mc_busy), 32'd0);
        step(1'b0, 5'b0, 5'b0, 1'b1, 6'd0);
        check("mc0_stall", 32'(stall), 32'h0);
        step(1'b0, 5'b0, 5'b0, 1'b0, 6'd0);
        check("mc0_done", 32'(mc_done), 32'd1);

        // Unblocked ex flush.
        step(1'b0, 5'b0, 5'b00100, 1'b0, 6'd0);
        check("ex_flush", 32'(flush), 32'h03);

        // ex flush held behind a mem stall.
        step(1'b0, 5'b01000, 5'b00100, 1'b0, 6'd0);
        check("blk_flush0", 32'(flush), 32'h0);
        step(1'b0, 5'b01000, 5'b0, 1'b0, 6'd0);
        step(1'b0, 5'b01000, 5'b0, 1'b0, 6'd0);
        step(1'b0, 5'b0, 5'b0, 1'b0, 6'd0);
        check("blk_release", 32'(flush), 32'h03);
        step(1'b0, 5'b0, 5'b0, 1'b0, 6'd0);
        check("blk_after", 32'(flush), 32'h0);

        // Ten-cycle op aborted by a mem flush in its third busy cycle.
        step(1'b0, 5'b0, 5'b0, 1'b1, 6'd10);
        step(1'b0, 5'b0, 5'b0, 1'b0, 6'd0);
        step(1'b0, 5'b0, 5'b01000, 1'b0, 6'd0);
        check("abort_flush", 32'(flush), 32'h07);
        step(1'b0, 5'b0, 5'b0, 1'b0, 6'd0);
        check("abort_busy", 32'(mc_busy), 32'd0);
        for (int i = 0; i < 10; i++) step(1'b0, 5'b0, 5'b0, 1'b0, 6'd0);

        // Six-cycle op cut by reset in its second busy cycle.
        step(1'b0, 5'b0, 5'b0, 1'b1, 6'd6);
        step(1'b1, 5'b0, 5'b0, 1'b0, 6'd0);
        check("rst_mid_stall", 32'(stall), 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 5'b0, 5'b0, 1'b0, 6'd0);
        check("rst_mid_cnt", stall_cycles, 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [STAGES-1:0] sr, fr;
            sr = STAGES'($urandom & $urandom & $urandom);
            fr = ($urandom_range(0, 4) == 0) ? STAGES'(1 << $urandom_range(0, STAGES - 1)) : '0;
            step($urandom_range(0, 99) == 0, sr, fr, $urandom_range(0, 7) == 0,
                 CW'($urandom_range(0, 12)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
